// File: rtl/sd_block_cache.sv
// Single-block write-back cache between a Wishbone CPU port and an SD block controller.
// Optional flush port pair is enabled by defining SD_BLOCK_CACHE_FLUSH_EN.
module sd_block_cache #(
   parameter int WORD_SIZE  = 32,
   parameter int BLOCK_BITS = 4096,
   parameter int SDSC       = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   input  logic                    we_i,
   input  logic [31:0]             addr_i,
   input  logic [WORD_SIZE/8-1:0]  sel_i,
   input  logic [WORD_SIZE-1:0]    dat_i,
   output logic [WORD_SIZE-1:0]    dat_o,
   output logic                    ack_o,
   output logic                    m_cyc,
   output logic                    m_stb,
   output logic                    m_we,
   output logic [31:0]             m_addr,
   output logic [BLOCK_BITS-1:0]   m_dat_o,
   input  logic [BLOCK_BITS-1:0]   m_dat_i,
   input  logic                    m_ack
`ifdef SD_BLOCK_CACHE_FLUSH_EN
   ,
   input  logic                    flush,
   output logic                    flush_done
`endif
);
   localparam int OFF_W = $clog2(BLOCK_BITS/8);
   localparam int WB_W  = $clog2(WORD_SIZE/8);
   localparam int IDX_W = OFF_W - WB_W;
   localparam int TAG_W = 32 - OFF_W;
   localparam int NB    = WORD_SIZE/8;

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_RESP} state_t;

   state_t                 r_state, w_next;
   logic [TAG_W-1:0]       r_tag, r_req_tag;
   logic [IDX_W-1:0]       r_req_idx;
   logic                   r_valid, r_dirty, r_gap, r_abort, r_we;
   logic [NB-1:0]          r_sel;
   logic [WORD_SIZE-1:0]   r_dat;
   logic [BLOCK_BITS-1:0]  r_buf;
   logic                   w_req, w_hit, w_abort, w_flush_req, w_flushing, w_fill_done;
   logic                   w_unused;

   assign w_unused    = ^addr_i[WB_W-1:0];
   assign w_req       = cyc_i & stb_i;
   assign w_hit       = r_valid && (r_tag == addr_i[31:OFF_W]);
   assign w_abort     = r_abort | ~cyc_i;
   assign w_fill_done = (r_state == S_FILL) && m_ack && !r_gap;

   function automatic logic [31:0] f_blk(input logic [TAG_W-1:0] t);
      if (SDSC != 0) return {t, {OFF_W{1'b0}}};
      else           return {{OFF_W{1'b0}}, t};
   endfunction

   always_ff @(posedge clock or posedge reset)
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;

   always_comb begin
      w_next  = r_state;
      ack_o   = 1'b0;
      dat_o   = '0;
      m_cyc   = 1'b0;
      m_stb   = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_dat_o = '0;
      case (r_state)
         S_IDLE:
            if (w_flush_req) begin
               if (r_valid && r_dirty) w_next = S_WB;
            end else if (w_req) begin
               if (w_hit)                   w_next = S_RESP;
               else if (r_valid && r_dirty) w_next = S_WB;
               else                         w_next = S_FILL;
            end
         S_WB: begin
            m_cyc   = 1'b1;
            m_stb   = 1'b1;
            m_we    = 1'b1;
            m_addr  = f_blk(r_tag);
            m_dat_o = r_buf;
            if (m_ack) w_next = (w_flushing || w_abort) ? S_IDLE : S_FILL;
         end
         S_FILL: begin
            // r_gap keeps the strobe low for one cycle after a writeback ack
            m_cyc  = ~r_gap;
            m_stb  = ~r_gap;
            m_addr = f_blk(r_req_tag);
            if (w_fill_done) w_next = w_abort ? S_IDLE : S_RESP;
         end
         S_RESP: begin
            ack_o  = 1'b1;
            if (!r_we) dat_o = r_buf[r_req_idx*WORD_SIZE +: WORD_SIZE];
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         r_tag     <= '0;
         r_valid   <= 1'b0;
         r_dirty   <= 1'b0;
         r_gap     <= 1'b0;
         r_abort   <= 1'b0;
         r_req_tag <= '0;
         r_req_idx <= '0;
         r_we      <= 1'b0;
         r_sel     <= '0;
         r_dat     <= '0;
      end else begin
         case (r_state)
            S_IDLE:
               if (!w_flush_req && w_req) begin
                  r_req_tag <= addr_i[31:OFF_W];
                  r_req_idx <= addr_i[OFF_W-1:WB_W];
                  r_we      <= we_i;
                  r_sel     <= sel_i;
                  r_dat     <= dat_i;
                  r_abort   <= 1'b0;
               end
            S_WB: begin
               if (!cyc_i) r_abort <= 1'b1;
               if (m_ack) begin
                  r_dirty <= 1'b0;
                  r_gap   <= (w_next == S_FILL);
               end
            end
            S_FILL: begin
               if (!cyc_i) r_abort <= 1'b1;
               r_gap <= 1'b0;
               if (w_fill_done) begin
                  r_tag   <= r_req_tag;
                  r_valid <= 1'b1;
                  r_dirty <= 1'b0;
               end
            end
            S_RESP:
               if (r_we) r_dirty <= 1'b1;
            default: ;
         endcase
      end

   // Data array carries no reset; valid gates every use of it.
   always_ff @(posedge clock)
      if (w_fill_done) r_buf <= m_dat_i;
      else if (r_state == S_RESP && r_we)
         for (int b = 0; b < NB; b++)
            if (r_sel[b]) r_buf[r_req_idx*WORD_SIZE + 8*b +: 8] <= r_dat[8*b +: 8];

`ifdef SD_BLOCK_CACHE_FLUSH_EN
   logic r_flush_pend, r_flushing, r_flush_done;
   assign w_flush_req = flush | r_flush_pend;
   assign w_flushing  = r_flushing;
   assign flush_done  = r_flush_done;

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         r_flush_pend <= 1'b0;
         r_flushing   <= 1'b0;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         if (r_state == S_IDLE && w_flush_req) begin
            r_flush_pend <= 1'b0;
            if (r_valid && r_dirty) r_flushing   <= 1'b1;
            else                    r_flush_done <= 1'b1;
         end else if (flush) r_flush_pend <= 1'b1;
         if (r_state == S_WB && r_flushing && m_ack) begin
            r_flushing   <= 1'b0;
            r_flush_done <= 1'b1;
         end
      end
`else
   assign w_flush_req = 1'b0;
   assign w_flushing  = 1'b0;
`endif
endmodule
